sub_bytes_shift_engine: RTL and testbench

- Iterative AES SubBytes + ShiftRows stage for the encryption datapath.
- Accepts a 128-bit state and streams its 16 bytes, one per cycle, through the team's existing combinational encryption S-box, which is instantiated outside this block.
- Each substituted byte is written to its ShiftRows destination. The finished 128-bit state is presented to the downstream MixColumns/AddRoundKey stage with a valid/ready handshake.

---
 rtl/sub_bytes_shift_engine.sv | 126 ++++++++++++
 tb/tb_sub_bytes_shift_engine.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_shift_engine.sv
// sub_bytes_shift_engine
// Iterative AES SubBytes + ShiftRows stage. A 128-bit state is captured, its
// 16 bytes are fed one per cycle to an external combinational S-box, and each
// substituted byte is written to its ShiftRows destination. The finished state
// is offered downstream until accepted.
//
// Handshake: an input state transfers on a rising edge where In_valid and
// In_ready are both high (In_ready is high only in IDLE). An output state is
// offered with Out_valid high and Data_out stable. It stays that way until
// Out_ready is sampled high on a rising edge. Flush aborts either side.
module sub_bytes_shift_engine #(
  parameter int SHIFT_ROWS = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Flush,
  input  logic         In_valid,
  output logic         In_ready,
  input  logic [127:0] Data_in,
  output logic [7:0]   SBOX_addr,
  input  logic [7:0]   SBOX_data,
  output logic         Out_valid,
  input  logic         Out_ready,
  output logic [127:0] Data_out,
  output logic         Busy,
  output logic [1:0]   o_dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [3:0]       r_cnt;
  // Byte k of the state lives at packed index 15-k (byte 0 is [127:120]).
  logic [15:0][7:0] r_in_buf;
  logic [15:0][7:0] r_out_buf;
  logic [1:0]       w_col;
  logic [1:0]       w_row;
  logic [1:0]       w_dst_col;
  logic [3:0]       w_dst;
  logic             w_accept;

  assign w_accept = (r_state == ST_IDLE) && In_valid;

  // Destination byte index for the byte currently being substituted.
  always_comb begin
    w_col     = r_cnt[3:2];
    w_row     = r_cnt[1:0];
    w_dst_col = w_col - w_row;
    if (SHIFT_ROWS != 0) begin
      w_dst = {w_dst_col, w_row};
    end else begin
      w_dst = r_cnt;
    end
  end

  // Next-state logic; Flush wins over every other event.
  always_comb begin
    w_next_state = r_state;
    if (Flush) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (In_valid)        w_next_state = ST_SUB;
        ST_SUB:  if (r_cnt == 4'd15)  w_next_state = ST_DONE;
        ST_DONE: if (Out_ready)       w_next_state = ST_IDLE;
        default:                      w_next_state = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Byte counter; the 15->0 wrap lines up with the move to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (Flush || w_accept) begin
      r_cnt <= 4'd0;
    end else if (r_state == ST_SUB) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Input buffer captures the state on an accepted handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_buf <= '0;
    end else if (!Flush && w_accept) begin
      r_in_buf <= Data_in;
    end
  end

  // Output buffer collects substituted bytes at their destination slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_buf <= '0;
    end else if (!Flush && (r_state == ST_SUB)) begin
      r_out_buf[~w_dst] <= SBOX_data;
    end
  end

  // S-box address comes straight from the registers; zero outside SUB.
  always_comb begin
    SBOX_addr = 8'h00;
    if (r_state == ST_SUB) begin
      SBOX_addr = r_in_buf[~r_cnt];
    end
  end

  assign In_ready    = (r_state == ST_IDLE);
  assign Out_valid   = (r_state == ST_DONE);
  assign Busy        = (r_state == ST_SUB) || (r_state == ST_DONE);
  assign Data_out    = r_out_buf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sub_bytes_shift_engine.sv
// Bench for sub_bytes_shift_engine: one instance with ShiftRows, one without,
// sharing all inputs; each has its own S-box lookup.
module tb_sub_bytes_shift_engine;

  localparam logic [2047:0] SBOX_TABLE = 2048'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0b7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b27509832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cfd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2cd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdbe0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08ba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9ee1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  always #5 clk = ~clk;

  logic         Flush;
  logic         In_valid;
  logic [127:0] Data_in;
  logic         Out_ready;

  logic         In_ready_1, Out_valid_1, Busy_1;
  logic [7:0]   SBOX_addr_1, SBOX_data_1;
  logic [127:0] Data_out_1;
  logic [1:0]   dbg_1;
  logic         In_ready_0, Out_valid_0, Busy_0;
  logic [7:0]   SBOX_addr_0, SBOX_data_0;
  logic [127:0] Data_out_0;
  logic [1:0]   dbg_0;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [2047:0] t;
    t = SBOX_TABLE;
    return t[(255 - int'(a)) * 8 +: 8];
  endfunction

  always_comb SBOX_data_1 = sbox(SBOX_addr_1);
  always_comb SBOX_data_0 = sbox(SBOX_addr_0);

  sub_bytes_shift_engine #(.SHIFT_ROWS(1)) dut_sr1 (
    .clk(clk), .reset(reset), .Flush(Flush), .In_valid(In_valid),
    .In_ready(In_ready_1), .Data_in(Data_in), .SBOX_addr(SBOX_addr_1),
    .SBOX_data(SBOX_data_1), .Out_valid(Out_valid_1), .Out_ready(Out_ready),
    .Data_out(Data_out_1), .Busy(Busy_1), .o_dbg_state(dbg_1)
  );

  sub_bytes_shift_engine #(.SHIFT_ROWS(0)) dut_sr0 (
    .clk(clk), .reset(reset), .Flush(Flush), .In_valid(In_valid),
    .In_ready(In_ready_0), .Data_in(Data_in), .SBOX_addr(SBOX_addr_0),
    .SBOX_data(SBOX_data_0), .Out_valid(Out_valid_0), .Out_ready(Out_ready),
    .Data_out(Data_out_0), .Busy(Busy_0), .o_dbg_state(dbg_0)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] exp_q1[$];
  logic [127:0] exp_q0[$];
  logic [127:0] last_exp1, last_exp0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  {In_ready_1, In_ready_0},   2'b11);
    chk({tag, "_out_valid"}, {Out_valid_1, Out_valid_0}, 2'b00);
    chk({tag, "_busy"},      {Busy_1, Busy_0},           2'b00);
    chk({tag, "_addr"},      {SBOX_addr_1, SBOX_addr_0}, 16'h0000);
  endtask

  // ---------------- driver tasks ----------------
  // Present a state for one cycle from IDLE; returns at the negedge after accept.
  task automatic start_vec(input logic [127:0] din, input logic [127:0] e1,
                           input logic [127:0] e0, input int hold);
    @(negedge clk);
    chk("pre_accept_in_ready", {In_ready_1, In_ready_0}, 2'b11);
    Data_in   = din;
    In_valid  = 1'b1;
    Out_ready = (hold == 0);
    exp_q1.push_back(e1);
    exp_q0.push_back(e0);
    @(negedge clk);
    In_valid = 1'b0;
    Data_in  = ~din;
  endtask

  // Step through SUB cycles first..last, checking the S-box address each cycle.
  task automatic run_sub(input logic [127:0] din, input int first, input int last);
    logic [127:0] d;
    d = din;
    for (int k = first; k <= last; k++) begin
      chk($sformatf("sub%0d_addr_sr1", k), SBOX_addr_1, d[127 - 8*k -: 8]);
      chk($sformatf("sub%0d_addr_sr0", k), SBOX_addr_0, d[127 - 8*k -: 8]);
      chk($sformatf("sub%0d_ctl", k), {Out_valid_1, In_ready_1, Busy_1}, 3'b001);
      @(negedge clk);
    end
  endtask

  // At DONE entry: check result, hold backpressure, then release.
  task automatic finish_done(input int hold);
    logic [127:0] e1, e0;
    chk("done_out_valid", {Out_valid_1, Out_valid_0}, 2'b11);
    chk("done_q_nonempty", (exp_q1.size() > 0) && (exp_q0.size() > 0), 1'b1);
    e1 = (exp_q1.size() > 0) ? exp_q1.pop_front() : '0;
    e0 = (exp_q0.size() > 0) ? exp_q0.pop_front() : '0;
    last_exp1 = e1;
    last_exp0 = e0;
    chk("done_data_sr1", Data_out_1, e1);
    chk("done_data_sr0", Data_out_0, e0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", h), {Out_valid_1, Out_valid_0, In_ready_1, Busy_1}, 4'b1101);
      chk($sformatf("bp%0d_data_sr1", h), Data_out_1, e1);
      chk($sformatf("bp%0d_data_sr0", h), Data_out_0, e0);
    end
    Out_ready = 1'b1;
    @(negedge clk);
    chk_idle("post_done");
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [127:0] din;
    logic [127:0] exp_sr1;
    logic [127:0] exp_sr0;
    int           hold;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vecs[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808,
                128'hd4bf5d30e0b452aeb84111f11e2798e5,
                128'hd42711aee0bf98f1b8b45de51e415230, 0};
    vecs[1] = '{128'h0,
                {16{8'h63}}, {16{8'h63}}, 0};
    vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f,
                128'h636b6776f201ab7b30d777c5fe7c6f2b,
                128'h637c777bf26b6fc53001672bfed7ab76, 5};
    vecs[3] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808,
                128'hd4bf5d30e0b452aeb84111f11e2798e5,
                128'hd42711aee0bf98f1b8b45de51e415230, 2};

    reset = 1'b1; Flush = 1'b0; In_valid = 1'b0; Data_in = '0; Out_ready = 1'b1;
    #2;
    chk_idle("reset");
    chk("reset_data_out", {Data_out_1, Data_out_0}, 256'h0);
    chk("reset_dbg_state", {dbg_1, dbg_0}, 4'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors: latency, data, SBOX_addr sequence, backpressure.
    for (int i = 0; i < 4; i++) begin
      start_vec(vecs[i].din, vecs[i].exp_sr1, vecs[i].exp_sr0, vecs[i].hold);
      run_sub(vecs[i].din, 0, 15);
      finish_done(vecs[i].hold);
    end

    // Asynchronous reset at SUB cycle 8.
    start_vec(vecs[0].din, vecs[0].exp_sr1, vecs[0].exp_sr0, 0);
    run_sub(vecs[0].din, 0, 7);
    #2 reset = 1'b1;
    #1;
    chk_idle("async_reset");
    chk("async_reset_data", {Data_out_1, Data_out_0}, 256'h0);
    exp_q1.delete();
    exp_q0.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("post_reset%0d_no_valid", c), {Out_valid_1, Out_valid_0, Busy_1}, 3'b000);
    end
    start_vec(vecs[2].din, vecs[2].exp_sr1, vecs[2].exp_sr0, 0);
    run_sub(vecs[2].din, 0, 15);
    finish_done(0);

    // Flush in DONE with a competing In_valid.
    start_vec(vecs[0].din, vecs[0].exp_sr1, vecs[0].exp_sr0, 1);
    run_sub(vecs[0].din, 0, 15);
    Out_ready = 1'b0;
    chk("flush_pre_valid", {Out_valid_1, Out_valid_0}, 2'b11);
    Flush    = 1'b1;
    In_valid = 1'b1;
    Data_in  = vecs[1].din;
    @(negedge clk);
    Flush    = 1'b0;
    In_valid = 1'b0;
    Out_ready = 1'b1;
    exp_q1.delete();
    exp_q0.delete();
    chk_idle("flush_done");
    chk("flush_keeps_buf_sr1", Data_out_1, vecs[0].exp_sr1);
    chk("flush_keeps_buf_sr0", Data_out_0, vecs[0].exp_sr0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("flush_not_accepted%0d", c), {Busy_1, Busy_0, dbg_1}, 4'b0000);
    end
    start_vec(vecs[2].din, vecs[2].exp_sr1, vecs[2].exp_sr0, 0);
    run_sub(vecs[2].din, 0, 15);
    finish_done(0);

    // Flush mid-SUB, then a full state must start again from byte 0.
    start_vec(vecs[2].din, vecs[2].exp_sr1, vecs[2].exp_sr0, 0);
    run_sub(vecs[2].din, 0, 3);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    exp_q1.delete();
    exp_q0.delete();
    chk_idle("flush_sub");
    start_vec(vecs[0].din, vecs[0].exp_sr1, vecs[0].exp_sr0, 0);
    run_sub(vecs[0].din, 0, 15);
    finish_done(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
